// File: rtl/vend_pkg.sv
// Shared types and defaults for the multi-item vending controller.
// The optional idle auto-refund is built only when VEND_TIMEOUT_EN is defined.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECTED = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } vend_state_t;

    localparam int unsigned DEF_NUM_ITEMS   = 4;
    localparam int unsigned DEF_ITEM_W      = 2;
    localparam int unsigned DEF_PRICE_W     = 8;
    localparam int unsigned DEF_CREDIT_W    = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 1000;

    localparam int unsigned PRICE_UNAVAIL   = 0;

endpackage

// File: rtl/vend_price_table.sv
// Per-item price register file: synchronous write, two asynchronous read ports.
// Out-of-range indices read as unavailable and are never written.
module vend_price_table
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS = DEF_NUM_ITEMS,
    parameter int unsigned ITEM_W    = DEF_ITEM_W,
    parameter int unsigned PRICE_W   = DEF_PRICE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wr_en,
    input  logic [ITEM_W-1:0]  i_wr_item,
    input  logic [PRICE_W-1:0] i_wr_price,
    input  logic [ITEM_W-1:0]  i_rd_item_a,
    output logic [PRICE_W-1:0] o_rd_price_a,
    input  logic [ITEM_W-1:0]  i_rd_item_b,
    output logic [PRICE_W-1:0] o_rd_price_b
);

    logic [PRICE_W-1:0] r_price [NUM_ITEMS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                r_price[i] <= PRICE_W'(PRICE_UNAVAIL);
            end
        end else if (i_wr_en && (32'(i_wr_item) < NUM_ITEMS)) begin
            r_price[i_wr_item] <= i_wr_price;
        end
    end

    assign o_rd_price_a = (32'(i_rd_item_a) < NUM_ITEMS) ? r_price[i_rd_item_a]
                                                         : PRICE_W'(PRICE_UNAVAIL);
    assign o_rd_price_b = (32'(i_rd_item_b) < NUM_ITEMS) ? r_price[i_rd_item_b]
                                                         : PRICE_W'(PRICE_UNAVAIL);

endmodule

// File: rtl/vend_multi_controller.sv
// Vending FSM: coin credit, item selection, dispense handshake, change/refund.
// Define VEND_TIMEOUT_EN to enable the idle auto-refund counter (TIMEOUT_CYC cycles).
module vend_multi_controller
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS   = DEF_NUM_ITEMS,
    parameter int unsigned ITEM_W      = DEF_ITEM_W,
    parameter int unsigned PRICE_W     = DEF_PRICE_W,
    parameter int unsigned CREDIT_W    = DEF_CREDIT_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_mode,
    input  logic                cfg_wr,
    input  logic [ITEM_W-1:0]   cfg_item,
    input  logic [PRICE_W-1:0]  cfg_price,
    input  logic                sel_valid,
    input  logic [ITEM_W-1:0]   sel_item,
    input  logic                coin_valid,
    input  logic [PRICE_W-1:0]  coin_value,
    input  logic                cancel,
    input  logic                dispense_ready,
    output logic                dispense_valid,
    output logic [ITEM_W-1:0]   dispense_item,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_value,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_err,
    output logic                busy
);

    vend_state_t         r_state;
    logic [ITEM_W-1:0]   r_item;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_dispense_valid;
    logic                r_change_valid;
    logic [CREDIT_W-1:0] r_change_value;
    logic                r_coin_reject;
    logic                r_sel_err;

    logic [PRICE_W-1:0]  w_sel_price;
    logic [PRICE_W-1:0]  w_cur_price;
    logic [CREDIT_W-1:0] w_cur_price_ext;
    logic [CREDIT_W:0]   w_sum;
    logic                w_active;
    logic                w_coin_ovf;
    logic                w_coin_acc;
    logic                w_coin_rej;
    logic [CREDIT_W-1:0] w_credit_after_coin;
    logic                w_sel_ok;
    logic                w_paid;
    logic [CREDIT_W-1:0] w_remain;
    logic                w_cfg_wr_en;
    logic                w_timeout;

    assign w_cfg_wr_en = cfg_wr && cfg_mode && (r_state == ST_IDLE);

    vend_price_table #(
        .NUM_ITEMS (NUM_ITEMS),
        .ITEM_W    (ITEM_W),
        .PRICE_W   (PRICE_W)
    ) u_price_table (
        .clk          (clk),
        .rst          (rst),
        .i_wr_en      (w_cfg_wr_en),
        .i_wr_item    (cfg_item),
        .i_wr_price   (cfg_price),
        .i_rd_item_a  (sel_item),
        .o_rd_price_a (w_sel_price),
        .i_rd_item_b  (r_item),
        .o_rd_price_b (w_cur_price)
    );

    assign w_active   = (r_state == ST_IDLE) || (r_state == ST_SELECTED);
    // One extra bit catches overflow of the credit accumulator.
    assign w_sum      = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value);
    assign w_coin_ovf = w_sum[CREDIT_W];
    assign w_coin_acc = coin_valid && !cfg_mode && w_active && !w_coin_ovf;
    assign w_coin_rej = coin_valid && !cfg_mode && w_active &&  w_coin_ovf;
    assign w_credit_after_coin = w_coin_acc ? w_sum[CREDIT_W-1:0] : r_credit;

    assign w_sel_ok = (32'(sel_item) < NUM_ITEMS) && (w_sel_price != PRICE_W'(PRICE_UNAVAIL));

    assign w_cur_price_ext = CREDIT_W'(w_cur_price);
    assign w_paid   = (w_cur_price != PRICE_W'(PRICE_UNAVAIL)) && (r_credit >= w_cur_price_ext);
    assign w_remain = r_credit - w_cur_price_ext;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_tmo_run;
    logic             w_tmo_clr;

    assign w_tmo_run = !cfg_mode &&
                       (((r_state == ST_IDLE) && (r_credit != '0)) || (r_state == ST_SELECTED));
    assign w_tmo_clr = !w_tmo_run || coin_valid || sel_valid;
    assign w_timeout = w_tmo_run && !w_tmo_clr && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_tmo_clr || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = (TIMEOUT_CYC == 0) && 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_item           <= '0;
            r_credit         <= '0;
            r_dispense_valid <= 1'b0;
            r_change_valid   <= 1'b0;
            r_change_value   <= '0;
            r_coin_reject    <= 1'b0;
            r_sel_err        <= 1'b0;
        end else begin
            r_change_valid <= 1'b0;
            r_change_value <= '0;
            r_coin_reject  <= 1'b0;
            r_sel_err      <= 1'b0;

            case (r_state)
                ST_IDLE, ST_SELECTED: begin
                    r_coin_reject <= w_coin_rej;
                    if (cfg_mode) begin
                        if (r_credit != '0) begin
                            r_state        <= ST_CHANGE;
                            r_change_valid <= 1'b1;
                            r_change_value <= r_credit;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (cancel || w_timeout) begin
                        // A same-cycle coin is folded into the refund.
                        r_credit <= w_credit_after_coin;
                        if (w_credit_after_coin != '0) begin
                            r_state        <= ST_CHANGE;
                            r_change_valid <= 1'b1;
                            r_change_value <= w_credit_after_coin;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_credit <= w_credit_after_coin;
                        if (sel_valid) begin
                            if (w_sel_ok) begin
                                r_item  <= sel_item;
                                r_state <= ST_SELECTED;
                            end else begin
                                r_sel_err <= 1'b1;
                            end
                        end else if ((r_state == ST_SELECTED) && w_paid) begin
                            r_state          <= ST_DISPENSE;
                            r_dispense_valid <= 1'b1;
                        end
                    end
                end

                ST_DISPENSE: begin
                    if (dispense_ready) begin
                        r_dispense_valid <= 1'b0;
                        if (w_remain != '0) begin
                            r_credit       <= w_remain;
                            r_state        <= ST_CHANGE;
                            r_change_valid <= 1'b1;
                            r_change_value <= w_remain;
                        end else begin
                            r_credit <= '0;
                            r_state  <= ST_IDLE;
                        end
                    end
                end

                ST_CHANGE: begin
                    r_credit <= '0;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dispense_valid = r_dispense_valid;
    assign dispense_item  = r_item;
    assign change_valid   = r_change_valid;
    assign change_value   = r_change_value;
    assign credit         = r_credit;
    assign coin_reject    = r_coin_reject;
    assign sel_err        = r_sel_err;
    assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vend_multi_controller.sv
// Self-checking bench for vend_multi_controller: purchase vector table plus corner sequences.
// Change/refund pulses are checked against a queue of expected amounts.
module tb_vend_multi_controller;

    localparam int unsigned TMO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_mode = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_item = '0;
    logic [7:0] cfg_price = '0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = '0;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_value = '0;
    logic       cancel = 1'b0;
    logic       dispense_ready = 1'b0;
    logic       dispense_valid;
    logic [1:0] dispense_item;
    logic       change_valid;
    logic [7:0] change_value;
    logic [7:0] credit;
    logic       coin_reject;
    logic       sel_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q [$];

    vend_multi_controller #(
        .NUM_ITEMS   (4),
        .ITEM_W      (2),
        .PRICE_W     (8),
        .CREDIT_W    (8),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_mode       (cfg_mode),
        .cfg_wr         (cfg_wr),
        .cfg_item       (cfg_item),
        .cfg_price      (cfg_price),
        .sel_valid      (sel_valid),
        .sel_item       (sel_item),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .cancel         (cancel),
        .dispense_ready (dispense_ready),
        .dispense_valid (dispense_valid),
        .dispense_item  (dispense_item),
        .change_valid   (change_valid),
        .change_value   (change_value),
        .credit         (credit),
        .coin_reject    (coin_reject),
        .sel_err        (sel_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard side: every change pulse must match the oldest expected amount.
    always @(negedge clk) begin
        if (!rst && change_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_change: got %0d, expected no pulse", change_value);
            end else begin
                check("change_value", 32'(change_value), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_price(input logic [1:0] item, input logic [7:0] price);
        cfg_mode  = 1'b1;
        cfg_wr    = 1'b1;
        cfg_item  = item;
        cfg_price = price;
        tick();
        cfg_wr    = 1'b0;
        cfg_mode  = 1'b0;
    endtask

    task automatic select(input logic [1:0] item);
        sel_valid = 1'b1;
        sel_item  = item;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic coin(input logic [7:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic wait_dispense(input string name);
        int unsigned n;
        n = 0;
        while (!dispense_valid && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(dispense_valid), 32'd1);
    endtask

    typedef struct packed {
        logic [1:0] item;
        logic [7:0] price;
        logic [1:0] ncoins;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [2:0] delay;
        logic [7:0] chg;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] sum;
        logic [7:0] cv;

        vecs[0] = '{2'd2, 8'd50,  2'd3, 8'd20,  8'd20, 8'd20, 3'd3, 8'd10};
        vecs[1] = '{2'd0, 8'd30,  2'd2, 8'd10,  8'd20, 8'd0,  3'd0, 8'd0};
        vecs[2] = '{2'd1, 8'd100, 2'd1, 8'd100, 8'd0,  8'd0,  3'd1, 8'd0};
        vecs[3] = '{2'd3, 8'd7,   2'd2, 8'd5,   8'd5,  8'd0,  3'd2, 8'd3};
        vecs[4] = '{2'd1, 8'd255, 2'd2, 8'd200, 8'd55, 8'd0,  3'd0, 8'd0};
        vecs[5] = '{2'd2, 8'd1,   2'd1, 8'd200, 8'd0,  8'd0,  3'd1, 8'd199};

        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_credit",   32'(credit),         32'd0);
        check("rst_dispense", 32'(dispense_valid), 32'd0);
        check("rst_change",   32'(change_valid),   32'd0);
        check("rst_busy",     32'(busy),           32'd0);
        check("rst_reject",   32'(coin_reject),    32'd0);
        check("rst_selerr",   32'(sel_err),        32'd0);

        // All prices are 0 after reset.
        select(2'd1);
        check("selerr_pulse", 32'(sel_err), 32'd1);
        check("selerr_idle",  32'(busy),    32'd0);
        tick();
        check("selerr_clear", 32'(sel_err), 32'd0);

        for (int i = 0; i < 6; i++) begin
            set_price(vecs[i].item, vecs[i].price);
            select(vecs[i].item);
            check("vec_selected", 32'(busy), 32'd1);
            sum = '0;
            for (int k = 0; k < int'(vecs[i].ncoins); k++) begin
                cv = (k == 0) ? vecs[i].c0 : (k == 1) ? vecs[i].c1 : vecs[i].c2;
                coin(cv);
                sum = sum + cv;
            end
            check("vec_credit", 32'(credit), 32'(sum));
            wait_dispense("vec_dispense");
            check("vec_item", 32'(dispense_item), 32'(vecs[i].item));
            for (int d = 0; d < int'(vecs[i].delay); d++) begin
                tick();
                check("vec_hold_valid", 32'(dispense_valid), 32'd1);
                check("vec_hold_item",  32'(dispense_item),  32'(vecs[i].item));
            end
            if (vecs[i].chg != 8'd0) exp_q.push_back(vecs[i].chg);
            dispense_ready = 1'b1;
            tick();
            dispense_ready = 1'b0;
            check("vec_valid_drop", 32'(dispense_valid), 32'd0);
            if (vecs[i].chg != 8'd0) tick();
            check("vec_end_credit", 32'(credit), 32'd0);
            check("vec_end_idle",   32'(busy),   32'd0);
        end

        // Cancel in SELECTED refunds everything.
        set_price(2'd1, 8'd100);
        select(2'd1);
        coin(8'd25);
        coin(8'd25);
        exp_q.push_back(8'd50);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        check("cancel_credit", 32'(credit), 32'd0);
        check("cancel_idle",   32'(busy),   32'd0);

        // Cancel during DISPENSE is ignored.
        select(2'd1);
        coin(8'd60);
        coin(8'd40);
        wait_dispense("cdisp_dispense");
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cdisp_valid",  32'(dispense_valid), 32'd1);
        check("cdisp_credit", 32'(credit),         32'd100);
        dispense_ready = 1'b1;
        tick();
        dispense_ready = 1'b0;
        check("cdisp_idle",   32'(busy),   32'd0);
        check("cdisp_credit0", 32'(credit), 32'd0);

        // Overflowing coin is rejected.
        coin(8'd250);
        coin(8'd10);
        check("ovf_reject", 32'(coin_reject), 32'd1);
        check("ovf_credit", 32'(credit),      32'd250);
        exp_q.push_back(8'd250);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("ovf_reject_pulse", 32'(coin_reject), 32'd0);
        tick();

        // Coin and cancel in the same cycle.
        coin(8'd40);
        exp_q.push_back(8'd45);
        coin_valid = 1'b1;
        coin_value = 8'd5;
        cancel     = 1'b1;
        tick();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        check("cc_busy", 32'(busy), 32'd1);
        tick();
        check("cc_credit", 32'(credit), 32'd0);

        // Selection and cancel in the same cycle: cancel wins.
        coin(8'd20);
        exp_q.push_back(8'd20);
        sel_valid = 1'b1;
        sel_item  = 2'd1;
        cancel    = 1'b1;
        tick();
        sel_valid = 1'b0;
        cancel    = 1'b0;
        check("sc_no_dispense", 32'(dispense_valid), 32'd0);
        tick();
        check("sc_idle", 32'(busy), 32'd0);

        // cfg_mode in SELECTED refunds, then coins are ignored.
        select(2'd1);
        coin(8'd15);
        exp_q.push_back(8'd15);
        cfg_mode = 1'b1;
        tick();
        tick();
        coin(8'd10);
        tick();
        check("cfg_credit", 32'(credit),      32'd0);
        check("cfg_reject", 32'(coin_reject), 32'd0);
        check("cfg_idle",   32'(busy),        32'd0);
        cfg_mode = 1'b0;

        // Asynchronous reset in DISPENSE.
        set_price(2'd2, 8'd50);
        select(2'd2);
        coin(8'd50);
        wait_dispense("rst_mid_dispense");
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",  32'(dispense_valid), 32'd0);
        check("arst_credit", 32'(credit),         32'd0);
        check("arst_busy",   32'(busy),           32'd0);
        #1;
        rst = 1'b0;
        tick();
        select(2'd2);
        check("arst_price_cleared", 32'(sel_err), 32'd1);

`ifdef VEND_TIMEOUT_EN
        begin
            int unsigned n;
            coin(8'd30);
            exp_q.push_back(8'd30);
            n = 0;
            while (!change_valid && n < TMO + 10) begin
                tick();
                n++;
            end
            check("tmo_fired", 32'(change_valid), 32'd1);
            check("tmo_not_early", 32'(n >= TMO - 2), 32'd1);
            tick();
        end
`endif

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
